// File: rtl/id_ex_decode_stage.sv
// ID stage of the RV64 subset core. It decodes one instruction into the control
// bundle, register indices and immediate, and registers the result into ID/EX.
module id_ex_decode_stage #(
    parameter int XLEN      = 64,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instruction,
    input  logic                 in_valid,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [1:0]           ALUOp,
    output logic [3:0]           funct,
    output logic                 Branch,
    output logic                 MemRead,
    output logic                 MemtoReg,
    output logic                 MemWrite,
    output logic                 ALUSrc,
    output logic                 RegWrite,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [4:0]           rd,
    output logic [XLEN-1:0]      imm,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] illegal_count
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    typedef struct packed {
        logic       vld;
        logic [1:0] aluop;
        logic [3:0] funct;
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [XLEN-1:0] imm;
        logic       illegal;
    } idex_t;

    idex_t                dec;
    idex_t                idex_q;
    logic [ILL_CNT_W-1:0] ill_cnt_q;

    always_comb begin
        dec       = '0;
        dec.vld   = 1'b1;
        dec.funct = {instruction[30], instruction[14:12]};
        dec.rs1   = instruction[19:15];
        dec.rs2   = instruction[24:20];
        dec.rd    = instruction[11:7];
        unique case (instruction[6:0])
            OP_R: begin
                dec.aluop    = 2'b10;
                dec.regwrite = 1'b1;
            end
            OP_IALU: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.imm      = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
            end
            OP_LD: begin
                dec.alusrc   = 1'b1;
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
                dec.regwrite = 1'b1;
                dec.imm      = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
            end
            OP_SD: begin
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
                dec.imm      = {{(XLEN-12){instruction[31]}}, instruction[31:25],
                                instruction[11:7]};
            end
            OP_BEQ: begin
                dec.aluop  = 2'b01;
                dec.branch = 1'b1;
                dec.imm    = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                              instruction[30:25], instruction[11:8], 1'b0};
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // A bubble is the all-zero bundle; the illegal counter survives flushes.
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q    <= '0;
            ill_cnt_q <= '0;
        end else if (flush) begin
            idex_q <= '0;
        end else if (!stall) begin
            if (in_valid) begin
                idex_q <= dec;
                if (dec.illegal && (ill_cnt_q != {ILL_CNT_W{1'b1}}))
                    ill_cnt_q <= ill_cnt_q + 1'b1;
            end else begin
                idex_q <= '0;
            end
        end
    end

    assign out_valid     = idex_q.vld;
    assign ALUOp         = idex_q.aluop;
    assign funct         = idex_q.funct;
    assign Branch        = idex_q.branch;
    assign MemRead       = idex_q.memread;
    assign MemtoReg      = idex_q.memtoreg;
    assign MemWrite      = idex_q.memwrite;
    assign ALUSrc        = idex_q.alusrc;
    assign RegWrite      = idex_q.regwrite;
    assign rs1           = idex_q.rs1;
    assign rs2           = idex_q.rs2;
    assign rd            = idex_q.rd;
    assign imm           = idex_q.imm;
    assign illegal       = idex_q.illegal;
    assign illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_id_ex_decode_stage.sv
// Directed bench for id_ex_decode_stage: hand-decoded vectors, stall/flush
// interaction and illegal-counter saturation.
module tb_id_ex_decode_stage;

    localparam int XLEN      = 64;
    localparam int ILL_CNT_W = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [31:0]          instruction;
    logic                 in_valid, stall, flush;
    logic                 out_valid;
    logic [1:0]           ALUOp;
    logic [3:0]           funct;
    logic                 Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
    logic [4:0]           rs1, rs2, rd;
    logic [XLEN-1:0]      imm;
    logic                 illegal;
    logic [ILL_CNT_W-1:0] illegal_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_decode_stage #(.XLEN(XLEN), .ILL_CNT_W(ILL_CNT_W)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .in_valid(in_valid),
        .stall(stall), .flush(flush), .out_valid(out_valid), .ALUOp(ALUOp),
        .funct(funct), .Branch(Branch), .MemRead(MemRead), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .rs1(rs1),
        .rs2(rs2), .rd(rd), .imm(imm), .illegal(illegal), .illegal_count(illegal_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ctrl = {Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite}
    task automatic expect_dec(input string tag, input logic v, input logic [1:0] aop,
                              input logic [3:0] fn, input logic [5:0] ctrl,
                              input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                              input logic [4:0] e_rd, input logic [63:0] e_imm,
                              input logic ill);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".aluop"}, 64'(ALUOp), 64'(aop));
        chk({tag, ".funct"}, 64'(funct), 64'(fn));
        chk({tag, ".ctrl"},  64'({Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite}),
            64'(ctrl));
        chk({tag, ".rs1"},   64'(rs1), 64'(e_rs1));
        chk({tag, ".rs2"},   64'(rs2), 64'(e_rs2));
        chk({tag, ".rd"},    64'(rd), 64'(e_rd));
        chk({tag, ".imm"},   imm, e_imm);
        chk({tag, ".ill"},   64'(illegal), 64'(ill));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins);
        instruction = ins;
        in_valid    = 1'b1;
        stall       = 1'b0;
        flush       = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; instruction = 32'h0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        expect_dec("reset", 0, 2'b00, 4'h0, 6'b000000, 0, 0, 0, 64'h0, 0);
        chk("reset.cnt", 64'(illegal_count), 64'd0);

        issue(32'h002081B3);
        expect_dec("add", 1, 2'b10, 4'b0000, 6'b000001, 1, 2, 3, 64'h0, 0);
        issue(32'h402081B3);
        expect_dec("sub", 1, 2'b10, 4'b1000, 6'b000001, 1, 2, 3, 64'h0, 0);
        issue(32'h00331313);
        expect_dec("slli", 1, 2'b00, 4'b0001, 6'b000011, 6, 3, 6, 64'd3, 0);
        issue(32'hFF813283);
        expect_dec("ld", 1, 2'b00, 4'b1011, 6'b011011, 2, 24, 5,
                   64'hFFFF_FFFF_FFFF_FFF8, 0);
        issue(32'h00513823);
        expect_dec("sd", 1, 2'b00, 4'b0011, 6'b000110, 2, 5, 16, 64'd16, 0);
        issue(32'hFE208EE3);
        expect_dec("beq", 1, 2'b01, 4'b1000, 6'b100000, 1, 2, 29,
                   64'hFFFF_FFFF_FFFF_FFFC, 0);

        // A valid-looking word with in_valid low must still produce a bubble.
        instruction = 32'h002081B3; in_valid = 1'b0;
        tick();
        expect_dec("novalid", 0, 2'b00, 4'h0, 6'b000000, 0, 0, 0, 64'h0, 0);

        issue(32'h002081B3);
        instruction = 32'hFF813283; in_valid = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_dec($sformatf("stall%0d", i), 1, 2'b10, 4'b0000, 6'b000001, 1, 2, 3,
                       64'h0, 0);
        end
        flush = 1'b1;
        tick();
        expect_dec("flushstall", 0, 2'b00, 4'h0, 6'b000000, 0, 0, 0, 64'h0, 0);

        for (int i = 0; i < 300; i++) begin
            issue(32'hFFFFFFFF);
            chk($sformatf("ill%0d.flag", i), 64'(illegal), 64'd1);
            chk($sformatf("ill%0d.cnt", i), 64'(illegal_count),
                64'((i + 1 > 255) ? 255 : i + 1));
        end
        expect_dec("illdec", 1, 2'b00, 4'hF, 6'b000000, 31, 31, 31, 64'h0, 1);

        instruction = 32'hFFFFFFFF; in_valid = 1'b1; flush = 1'b1;
        tick();
        chk("flush.cnt", 64'(illegal_count), 64'd255);
        chk("flush.ill", 64'(illegal), 64'd0);
        chk("flush.valid", 64'(out_valid), 64'd0);

        // Stalled illegal word must not bump the count.
        flush = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        issue(32'hFFFFFFFF);
        chk("cnt1", 64'(illegal_count), 64'd1);
        stall = 1'b1;
        tick();
        tick();
        chk("stall.cnt", 64'(illegal_count), 64'd1);
        chk("stall.ill", 64'(illegal), 64'd1);

        // Reset while stalling clears everything.
        reset = 1'b1;
        tick();
        reset = 1'b0; stall = 1'b0; in_valid = 1'b0;
        expect_dec("rststall", 0, 2'b00, 4'h0, 6'b000000, 0, 0, 0, 64'h0, 0);
        chk("rststall.cnt", 64'(illegal_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_decode_stage.md
Name: id_ex_decode_stage

Overview:
- Instruction decode stage for the RV64 subset core, feeding the ID/EX pipeline register.
- Produces the main control bundle from a fetched instruction: ALUOp, the 4-bit funct {instr[30], instr[14:12]}, datapath enables, register indices and the sign-extended immediate.
- The 4-bit funct field is the code that the ALU control decoder consumes to select operation.
- All outputs are registered: one-cycle decode, with stall, flush and illegal-opcode tracking.

Parameters:
- XLEN, 64, immediate output width; sign extension fills up to XLEN.
- ILL_CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- instruction  input  32  instruction word from IF/ID.
- in_valid  input  1  instruction is valid this cycle.
- stall  input  1  hold all ID/EX outputs.
- flush  input  1  replace the ID/EX contents with a bubble.
- out_valid  output  1  the ID/EX slot holds a real instruction.
- ALUOp  output  2  00 = I/load/store, 01 = branch, 10 = R-type.
- funct  output  4  {instr[30], instr[14:12]}.
- Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite  output  1 each  datapath controls.
- rs1, rs2, rd  output  5 each  register indices.
- imm  output  XLEN  sign-extended immediate.
- illegal  output  1  the registered instruction had an unsupported opcode.
- illegal_count  output  ILL_CNT_W  count of illegal instructions accepted.

Behaviour:
- Reset (synchronous, highest priority): every output, including illegal_count, is 0.
- Per-edge priority: reset > flush > stall > load.
- flush: load a bubble. All controls = 0, out_valid = 0, illegal = 0, ALUOp = 00, funct = 0, rs1/rs2/rd = 0, imm = 0. illegal_count is unchanged.
- stall (without flush): every output holds, including illegal_count.
- load with in_valid = 0: load a bubble.
- load with in_valid = 1: register the decode of instruction; out_valid = 1. Latency is exactly 1 cycle from input to output.
- Decode by opcode = instr[6:0]:
  - 0110011 (R): ALUOp = 10, RegWrite = 1, ALUSrc = 0, imm = 0.
  - 0010011 (I-ALU): ALUOp = 00, ALUSrc = 1, RegWrite = 1, imm = sext(instr[31:20]).
  - 0000011 (ld): ALUOp = 00, ALUSrc = 1, MemRead = 1, MemtoReg = 1, RegWrite = 1, imm = sext(instr[31:20]).
  - 0100011 (sd): ALUOp = 00, ALUSrc = 1, MemWrite = 1, imm = sext({instr[31:25], instr[11:7]}).
  - 1100011 (beq): ALUOp = 01, Branch = 1, imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - Any other opcode: all controls = 0, imm = 0, illegal = 1, out_valid = 1. illegal_count increments and saturates at all-ones.
- Unlisted controls are 0 for each opcode.
- funct = {instr[30], instr[14:12]} for every valid opcode, including illegal ones; 0 for bubbles.
- rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7] for every valid load. Indices are passed through unmasked; downstream qualifies them with the enables.
- Sign extension: bit 31 of the instruction replicates to imm[XLEN-1].
- Simultaneous flush and stall: flush wins, and the bubble is loaded.
- Reset asserted mid-stall: reset wins, and the stall is ignored that cycle.

Test Plan:
- Reset held 2 cycles, then released with in_valid = 0 -> all outputs 0, out_valid = 0, illegal_count = 0.
- 0x002081B3 (add x3,x1,x2) -> next cycle: out_valid = 1, ALUOp = 10, funct = 0000, RegWrite = 1, rs1 = 1, rs2 = 2, rd = 3, imm = 0.
- 0x402081B3 (sub) -> funct = 1000, ALUOp = 10.
- 0x00331313 (slli x6,x6,3) -> funct = 0001, ALUOp = 00, ALUSrc = 1, imm = 3.
- 0xFF813283 (ld x5,-8(x2)) -> MemRead = MemtoReg = RegWrite = ALUSrc = 1, rd = 5, imm = 0xFFFFFFFFFFFFFFF8.
- 0x00513823 (sd x5,16(x2)) -> MemWrite = 1, RegWrite = 0, rs2 = 5, imm = 16.
- 0xFE208EE3 (beq x1,x2,-4) -> ALUOp = 01, Branch = 1, imm = 0xFFFFFFFFFFFFFFFC.
- Load add, then stall for 3 cycles while the input changes -> outputs hold the add decode. Then flush with stall = 1 -> bubble, out_valid = 0.
- 300 consecutive 0xFFFFFFFF (illegal) -> illegal = 1 each cycle, illegal_count saturates at 255.
- Then one flush cycle -> count stays 255, illegal = 0.
